// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: result = a - b, truncating, with
// a five-state control path (IDLE, ALIGN, ADD, NORM, DONE) and valid/ready handshakes.
module fp_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        zero
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic [31:0] a_r, b_r;
    logic        sign_r, sub_r, nan_r, ovf_p_r, negz_r;
    logic [7:0]  exp_r;
    logic [23:0] sig_r, sml_r;
    logic [31:0] result_r;
    logic        ovf_r, zero_r;

    // Operand decode and alignment, consumed in ALIGN.
    logic        sa, sb, a_big;
    logic [7:0]  ea, eb, e_big, e_sml, diff;
    logic [22:0] fa, fb;
    logic [23:0] siga, sigb, sig_big, sig_sml, sml_shift;
    logic [24:0] sum;
    logic [7:0]  exp_inc;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // so no latch is inferred.
    always_comb begin
        sa        = a_r[31];
        sb        = ~b_r[31];
        ea        = a_r[30:23];
        eb        = b_r[30:23];
        fa        = a_r[22:0];
        fb        = b_r[22:0];
        siga      = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
        sigb      = (eb == 8'd0) ? 24'd0 : {1'b1, fb};
        a_big     = ({ea, fa} >= {eb, fb});
        e_big     = a_big ? ea : eb;
        e_sml     = a_big ? eb : ea;
        sig_big   = a_big ? siga : sigb;
        sig_sml   = a_big ? sigb : siga;
        diff      = e_big - e_sml;
        sml_shift = (diff >= 8'd25) ? 24'd0 : (sig_sml >> diff);
        sum       = sub_r ? ({1'b0, sig_r} - {1'b0, sml_r})
                          : ({1'b0, sig_r} + {1'b0, sml_r});
        exp_inc   = exp_r + 8'd1;
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: datapath registers are reset alongside the control state so that
    // an abort leaves no stale result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            sign_r   <= 1'b0;
            sub_r    <= 1'b0;
            nan_r    <= 1'b0;
            ovf_p_r  <= 1'b0;
            negz_r   <= 1'b0;
            exp_r    <= 8'd0;
            sig_r    <= 24'd0;
            sml_r    <= 24'd0;
            result_r <= 32'd0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_r  <= a_big ? sa : sb;
                    sub_r   <= sa ^ sb;
                    nan_r   <= (ea == 8'hFF) || (eb == 8'hFF);
                    negz_r  <= (ea == 8'd0) && (eb == 8'd0) && sa && sb;
                    exp_r   <= e_big;
                    sig_r   <= sig_big;
                    sml_r   <= sml_shift;
                    state   <= ADD;
                end
                ADD: begin
                    if (sum[24]) begin
                        sig_r <= sum[24:1];
                        exp_r <= exp_inc;
                    end else begin
                        sig_r <= sum[23:0];
                    end
                    ovf_p_r <= sum[24] && (exp_inc == 8'hFF);
                    state   <= NORM;
                end
                NORM: begin
                    // Priority: special operand, overflow, zero, normalised, underflow, shift.
                    if (nan_r) begin
                        result_r <= 32'h7FC0_0000;
                        ovf_r    <= 1'b0;
                        zero_r   <= 1'b0;
                        state    <= DONE;
                    end else if (ovf_p_r) begin
                        result_r <= {sign_r, 8'hFF, 23'd0};
                        ovf_r    <= 1'b1;
                        zero_r   <= 1'b0;
                        state    <= DONE;
                    end else if (sig_r == 24'd0) begin
                        result_r <= negz_r ? 32'h8000_0000 : 32'h0000_0000;
                        ovf_r    <= 1'b0;
                        zero_r   <= 1'b1;
                        state    <= DONE;
                    end else if (sig_r[23]) begin
                        result_r <= {sign_r, exp_r, sig_r[22:0]};
                        ovf_r    <= 1'b0;
                        zero_r   <= 1'b0;
                        state    <= DONE;
                    end else if (exp_r == 8'd1) begin
                        result_r <= 32'h0000_0000;
                        ovf_r    <= 1'b0;
                        zero_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        sig_r <= {sig_r[22:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule
